uart_post_monitor: RTL and testbench



---
 rtl/uart_post_monitor.sv | 170 +++++++++++++++++
 tb/tb_uart_post_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_post_monitor.sv
// 8N1 UART receiver on the SoC TX pin plus a PASS/FAIL verdict scanner.
// Bytes come out as one-cycle pulses. The verdict flags stay set until reset.
module uart_post_monitor #(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [31:0] PASS_WORD    = 32'h50415353,
    parameter logic [31:0] FAIL_WORD    = 32'h4641494C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err,
    output logic [15:0] byte_count,
    output logic [7:0]  err_count,
    output logic        pass_seen,
    output logic        fail_seen,
    output logic        busy
);
    // state | meaning
    // IDLE  | line idle, waiting for a falling edge on rx_s
    // START | counting to the middle of the start bit, rejects short glitches
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | sampling the stop bit
    // BREAK | stop bit was low; hold until the line returns high
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [11:0] BIT_M1  = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [11:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_byte_valid;
    logic [7:0]  r_byte_data;
    logic        r_frame_err;
    logic [15:0] r_byte_count;
    logic [7:0]  r_err_count;
    logic [23:0] r_window;
    logic        r_pass_seen;
    logic        r_fail_seen;

    logic        w_rx_fall;
    logic        w_baud_tc;
    logic [31:0] w_window_next;

    assign w_rx_fall     = r_rx_prev & ~r_rx_s;
    assign w_baud_tc     = (r_baud_cnt == 12'd0);
    // Only the newest three bytes need storing; the fourth is the byte on r_byte_data.
    assign w_window_next = {r_window, r_byte_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_baud_cnt   <= 12'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'h00;
            r_frame_err  <= 1'b0;
            r_byte_count <= 16'h0000;
            r_err_count  <= 8'h00;
        end else begin
            r_rx_meta    <= rx;
            r_rx_s       <= r_rx_meta;
            r_rx_prev    <= r_rx_s;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rx_fall) begin
                        r_state    <= START;
                        r_bit_cnt  <= 3'd0;
                        r_baud_cnt <= HALF_M1;
                    end
                end
                START: begin
                    if (w_baud_tc) begin
                        if (!r_rx_s) begin
                            r_state    <= DATA;
                            r_baud_cnt <= BIT_M1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 12'd1;
                    end
                end
                DATA: begin
                    if (w_baud_tc) begin
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        r_baud_cnt <= BIT_M1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 12'd1;
                    end
                end
                STOP: begin
                    if (w_baud_tc) begin
                        if (r_rx_s) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                            if (r_byte_count != 16'hFFFF) begin
                                r_byte_count <= r_byte_count + 16'd1;
                            end
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_state <= BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 12'd1;
                    end
                end
                BREAK: begin
                    if (r_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_window    <= 24'h000000;
            r_pass_seen <= 1'b0;
            r_fail_seen <= 1'b0;
        end else if (r_byte_valid) begin
            r_window <= w_window_next[23:0];
            if (w_window_next == PASS_WORD) begin
                r_pass_seen <= 1'b1;
            end
            if (w_window_next == FAIL_WORD) begin
                r_fail_seen <= 1'b1;
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign frame_err  = r_frame_err;
    assign byte_count = r_byte_count;
    assign err_count  = r_err_count;
    assign pass_seen  = r_pass_seen;
    assign fail_seen  = r_fail_seen;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_post_monitor.sv
// Bench for uart_post_monitor: table-driven frames plus hand-written break, glitch,
// reset-abort and saturation sequences, with a byte scoreboard.
module tb_uart_post_monitor;
    localparam int          CPB    = 16;
    localparam logic [31:0] PASS_W = 32'h50415353;
    localparam logic [31:0] FAIL_W = 32'h4641494C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;
    logic [15:0] byte_count;
    logic [7:0]  err_count;
    logic        pass_seen;
    logic        fail_seen;
    logic        busy;

    uart_post_monitor #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .byte_count (byte_count),
        .err_count  (err_count),
        .pass_seen  (pass_seen),
        .fail_seen  (fail_seen),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // pass0/fail0: flags in the byte_valid cycle; pass1/fail1: one cycle later
    typedef struct {
        logic [7:0]  data;
        logic [15:0] count;
        logic        pass0, fail0, pass1, fail1;
    } cap_t;

    cap_t got_q[$];
    cap_t exp_q[$];
    cap_t pend;
    logic pend_v    = 1'b0;
    int   n_ferr    = 0;
    logic mutex_bad = 1'b0;

    always @(negedge clk) begin
        if (pend_v) begin
            pend.pass1 = pass_seen;
            pend.fail1 = fail_seen;
            got_q.push_back(pend);
            pend_v = 1'b0;
        end
        if (byte_valid) begin
            pend.data  = byte_data;
            pend.count = byte_count;
            pend.pass0 = pass_seen;
            pend.fail0 = fail_seen;
            pend_v     = 1'b1;
        end
        if (frame_err) n_ferr++;
        if (byte_valid && frame_err) mutex_bad = 1'b1;
    end

    int          n_chk = 0;
    int          n_pass = 0;
    int          rd_idx = 0;
    logic [31:0] m_window;
    logic        m_pass, m_fail;
    int          m_good, m_base, m_err;
    logic [7:0]  m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_count();
        return (m_base + m_good > 32'hFFFF) ? 16'hFFFF : 16'(m_base + m_good);
    endfunction

    task automatic model_reset();
        m_window = 32'h0;
        m_pass = 1'b0;
        m_fail = 1'b0;
        m_good = 0;
        m_base = 0;
        m_err  = 0;
        m_last = 8'h00;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rd_idx = got_q.size();
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    // Caller is at a negedge; the frame ends with rx left high.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        cap_t e;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (stop) begin
            m_good++;
            e.data  = data;
            e.count = exp_count();
            e.pass0 = m_pass;
            e.fail0 = m_fail;
            m_window = {m_window[23:0], data};
            if (m_window == PASS_W) m_pass = 1'b1;
            if (m_window == FAIL_W) m_fail = 1'b1;
            e.pass1 = m_pass;
            e.fail1 = m_fail;
            m_last  = data;
            exp_q.push_back(e);
        end else begin
            m_err++;
        end
    endtask

    task automatic drain(input string tag);
        cap_t e, g;
        int   waited;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            waited = 0;
            while (got_q.size() <= rd_idx && waited < 30 * CPB) begin
                @(negedge clk);
                waited++;
            end
            if (got_q.size() <= rd_idx) begin
                n_chk++;
                $display("FAIL %s timeout: no byte_valid seen, expected byte 0x%02h", tag, e.data);
            end else begin
                g = got_q[rd_idx];
                rd_idx++;
                check({tag, " byte_data"},  g.data,  e.data);
                check({tag, " byte_count"}, g.count, e.count);
                check({tag, " pass@valid"}, g.pass0, e.pass0);
                check({tag, " pass@+1"},    g.pass1, e.pass1);
                check({tag, " fail@valid"}, g.fail0, e.fail0);
                check({tag, " fail@+1"},    g.fail1, e.fail1);
            end
        end
        repeat (2) @(negedge clk);
        check({tag, " no extra bytes"}, got_q.size(), rd_idx);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vt[6];

    initial begin
        int   fe0, bv0, base_sz;
        logic saw_busy;
        logic [7:0] msg[6];
        logic [7:0] fw[4];
        logic [7:0] sat_bytes[3];

        vt[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vt[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vt[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vt[4] = '{8'h01, 1'b0, 1'b0, 1'b1};
        vt[5] = '{8'hC3, 1'b1, 1'b1, 1'b0};
        msg = '{8'h78, 8'h50, 8'h41, 8'h53, 8'h53, 8'h0A};
        fw  = '{8'h46, 8'h41, 8'h49, 8'h4C};
        sat_bytes = '{8'h11, 8'h22, 8'h7E};

        // reset state
        repeat (3) @(negedge clk);
        check("rst byte_valid", byte_valid, 1'b0);
        check("rst byte_data",  byte_data,  8'h00);
        check("rst frame_err",  frame_err,  1'b0);
        check("rst byte_count", byte_count, 16'h0);
        check("rst err_count",  err_count,  8'h0);
        check("rst pass_seen",  pass_seen,  1'b0);
        check("rst fail_seen",  fail_seen,  1'b0);
        check("rst busy",       busy,       1'b0);
        do_reset();

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            bv0 = got_q.size();
            fe0 = n_ferr;
            send_frame(vt[i].data, vt[i].stop);
            idle(2);
            check($sformatf("vec%0d valid", i), got_q.size() - bv0, {31'b0, vt[i].exp_valid});
            check($sformatf("vec%0d frame_err", i), n_ferr - fe0, {31'b0, vt[i].exp_ferr});
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d held byte_data", i), byte_data, m_last);
            check($sformatf("vec%0d err_count", i), err_count, m_err[7:0]);
            check($sformatf("vec%0d byte_count", i), byte_count, exp_count());
            check($sformatf("vec%0d busy", i), busy, 1'b0);
        end

        // "xPASS\n" back to back
        do_reset();
        for (int i = 0; i < 6; i++) send_frame(msg[i], 1'b1);
        idle(2);
        drain("xpass");
        check("xpass byte_count", byte_count, 16'd6);
        check("xpass pass_seen", pass_seen, 1'b1);
        check("xpass fail_seen", fail_seen, 1'b0);

        // bad stop bit, long break, then a good byte
        do_reset();
        fe0 = n_ferr;
        send_frame(8'hA3, 1'b0);
        rx = 1'b0;
        repeat (100 * CPB) @(negedge clk);
        check("break busy held", busy, 1'b1);
        idle(3);
        check("break frame_err pulses", n_ferr - fe0, 1);
        check("break err_count", err_count, 8'd1);
        check("break byte_count", byte_count, 16'd0);
        send_frame(8'h41, 1'b1);
        idle(2);
        drain("break");
        check("break byte_data", byte_data, 8'h41);
        check("break byte_count after", byte_count, 16'd1);
        check("break err_count after", err_count, 8'd1);

        // short glitch on an idle line
        do_reset();
        fe0 = n_ferr;
        base_sz = got_q.size();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        saw_busy = busy;
        rx = 1'b1;
        for (int w = 0; w < 10 && busy; w++) @(negedge clk);
        check("glitch started busy", saw_busy, 1'b1);
        check("glitch busy cleared", busy, 1'b0);
        idle(2);
        check("glitch no bytes", got_q.size(), base_sz);
        check("glitch no frame_err", n_ferr - fe0, 0);
        check("glitch byte_count", byte_count, 16'd0);
        check("glitch err_count", err_count, 8'd0);

        // reset in the middle of data bit 4 of 0xFF, then "FAIL"
        do_reset();
        fe0 = n_ferr;
        base_sz = got_q.size();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + 6) @(negedge clk);
        check("abort busy in data", busy, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort busy after rst", busy, 1'b0);
        idle(6);
        check("abort no bytes", got_q.size(), base_sz);
        check("abort no frame_err", n_ferr - fe0, 0);
        model_reset();
        rd_idx = got_q.size();
        for (int i = 0; i < 4; i++) begin
            send_frame(fw[i], 1'b1);
            idle(1);
        end
        idle(1);
        drain("fail");
        check("fail fail_seen", fail_seen, 1'b1);
        check("fail pass_seen", pass_seen, 1'b0);
        check("fail byte_count", byte_count, 16'd4);

        // byte_count saturation from 0xFFFE
        do_reset();
        dut.r_byte_count = 16'hFFFE;
        m_base = 32'hFFFE;
        @(negedge clk);
        check("sat preset", byte_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            send_frame(sat_bytes[i], 1'b1);
            idle(1);
        end
        idle(1);
        drain("sat");
        check("sat byte_count", byte_count, 16'hFFFF);
        check("sat byte_data", byte_data, 8'h7E);

        check("valid/frame_err exclusive", mutex_bad, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global timeout: bench did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
